// File: rtl/note_source_arbiter.sv
// Note source arbiter: picks song sequencer, manual keys or silence.
// Optional macro KEY_OVERRIDE_EN lets keys interrupt a playing song.
module note_source_arbiter #(
    parameter int BASE_TICKS  = 12_500_000,
    parameter int RELEASE_CYC = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] KEYS,
    input  logic       PLAY_BTN,
    input  logic       STOP_BTN,
    input  logic [1:0] TEMPO,
    input  logic [3:0] AUTO_NOTE,
    output logic       QUARTER_BEAT,
    output logic       SONG_START,
    output logic [3:0] NOTE,
    output logic [1:0] SRC
);

    localparam int CW = $clog2(BASE_TICKS * 2);
    localparam int RW = $clog2(RELEASE_CYC + 1);

    localparam logic [CW-1:0] LAST_BASE = CW'(BASE_TICKS - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(BASE_TICKS / 2 - 1);
    localparam logic [CW-1:0] LAST_DBL  = CW'(BASE_TICKS * 2 - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYC - 1);

    // Encoding doubles as the SRC output code.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_AUTO  = 2'b01,
        S_MAN   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    state_t        r_state;
    state_t        r_ret;
    logic [RW-1:0] r_rel;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_tempo;
    logic [3:0]    r_note;
    logic          r_qb;
    logic          r_ss;

    state_t        w_next;
    state_t        w_ret;
    logic [RW-1:0] w_rel;
    logic [CW-1:0] w_last;
    logic          w_wrap;
    logic          w_keys;
    logic          w_key_ovr;
    logic          w_start;
    logic [3:0]    w_low;
    logic [3:0]    w_note;

    assign w_keys = |KEYS;

`ifdef KEY_OVERRIDE_EN
    assign w_key_ovr = w_keys;
`else
    assign w_key_ovr = 1'b0;
`endif

    // Last count of the current quarter beat for the latched tempo.
    always_comb begin
        w_last = LAST_BASE;
        case (r_tempo)
            2'd1:    w_last = LAST_HALF;
            2'd2:    w_last = LAST_DBL;
            default: w_last = LAST_BASE;
        endcase
    end

    assign w_wrap = (r_state == S_AUTO) && (r_cnt == w_last);

    // Lowest-numbered pressed key wins; 8 when no key is down.
    always_comb begin
        w_low = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (KEYS[i]) w_low = 4'(i);
        end
    end

    // Next state, return state and release counter.
    always_comb begin
        w_next = r_state;
        w_ret  = r_ret;
        w_rel  = r_rel;
        unique case (r_state)
            S_IDLE: begin
                if (!STOP_BTN) begin
                    if (w_keys) begin
                        w_next = S_MAN;
                        w_ret  = S_IDLE;
                        w_rel  = '0;
                    end else if (PLAY_BTN) begin
                        w_next = S_AUTO;
                    end
                end
            end
            S_AUTO: begin
                if (STOP_BTN) begin
                    w_next = S_IDLE;
                end else if (w_key_ovr) begin
                    w_next = S_MAN;
                    w_ret  = S_AUTO;
                    w_rel  = '0;
                end else if (PLAY_BTN) begin
                    w_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (STOP_BTN) begin
                    w_next = S_IDLE;
                end else if (w_keys) begin
                    w_next = S_MAN;
                    w_ret  = S_PAUSE;
                    w_rel  = '0;
                end else if (PLAY_BTN) begin
                    w_next = S_AUTO;
                end
            end
            S_MAN: begin
                if (STOP_BTN) w_ret = S_IDLE;
                if (w_keys) begin
                    w_rel = '0;
                end else if (r_rel == REL_LAST) begin
                    w_rel  = '0;
                    w_next = w_ret;
                end else begin
                    w_rel = r_rel + 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_start = (r_state == S_IDLE) && (w_next == S_AUTO);

    // Note presented in the state being entered.
    always_comb begin
        w_note = 4'd8;
        unique case (w_next)
            S_AUTO:  w_note = AUTO_NOTE;
            S_MAN:   w_note = w_low;
            default: w_note = 4'd8;
        endcase
    end

    // State, return state, release counter and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
            r_rel   <= '0;
            r_note  <= 4'd8;
            r_qb    <= 1'b0;
            r_ss    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret;
            r_rel   <= w_rel;
            r_note  <= w_note;
            r_qb    <= w_wrap;
            r_ss    <= w_start;
        end
    end

    // Beat counter runs only in AUTO and restarts whenever IDLE is entered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (w_next == S_IDLE || w_wrap) begin
            r_cnt <= '0;
        end else if (r_state == S_AUTO) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tempo changes take effect only at a beat boundary or song start.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tempo <= 2'd0;
        end else if (w_wrap || w_start) begin
            r_tempo <= TEMPO;
        end
    end

    assign QUARTER_BEAT = r_qb;
    assign SONG_START   = r_ss;
    assign NOTE         = r_note;
    assign SRC          = r_state;

endmodule

// File: tb/tb_note_source_arbiter.sv
// Scoreboard bench for note_source_arbiter (BASE_TICKS=8, RELEASE_CYC=4).
// Expected outputs come from a cycle-level behavioural model of the modes.
module tb_note_source_arbiter;

    localparam int B   = 8;
    localparam int REL = 4;

    localparam int M_IDLE  = 0;
    localparam int M_AUTO  = 1;
    localparam int M_MAN   = 2;
    localparam int M_PAUSE = 3;

`ifdef KEY_OVERRIDE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] KEYS;
    logic       PLAY_BTN;
    logic       STOP_BTN;
    logic [1:0] TEMPO;
    logic [3:0] AUTO_NOTE;
    logic       QUARTER_BEAT;
    logic       SONG_START;
    logic [3:0] NOTE;
    logic [1:0] SRC;

    note_source_arbiter #(
        .BASE_TICKS (B),
        .RELEASE_CYC(REL)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .KEYS        (KEYS),
        .PLAY_BTN    (PLAY_BTN),
        .STOP_BTN    (STOP_BTN),
        .TEMPO       (TEMPO),
        .AUTO_NOTE   (AUTO_NOTE),
        .QUARTER_BEAT(QUARTER_BEAT),
        .SONG_START  (SONG_START),
        .NOTE        (NOTE),
        .SRC         (SRC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       qb;
        logic       ss;
        logic [3:0] note;
        logic [1:0] src;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: mode, mode to return to after keys, beat phase/period.
    int m_mode, m_ret, m_phase, m_period, m_rel;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    function automatic int period_of(logic [1:0] t);
        if (t == 2'd1) return B / 2;
        if (t == 2'd2) return B * 2;
        return B;
    endfunction

    function automatic int lowest_key(logic [7:0] k);
        for (int i = 0; i < 8; i++) if (k[i]) return i;
        return 8;
    endfunction

    function automatic void m_reset();
        m_mode   = M_IDLE;
        m_ret    = M_IDLE;
        m_phase  = 0;
        m_period = B;
        m_rel    = 0;
    endfunction

    // One clock of behaviour given the inputs currently applied.
    function automatic exp_t m_step();
        exp_t e;
        int nm;
        e.qb = 1'b0;
        e.ss = 1'b0;
        nm = m_mode;
        if (m_mode == M_AUTO) begin
            if (m_phase == m_period - 1) begin
                e.qb     = 1'b1;
                m_phase  = 0;
                m_period = period_of(TEMPO);
            end else begin
                m_phase++;
            end
        end
        case (m_mode)
            M_IDLE: begin
                if (STOP_BTN) nm = M_IDLE;
                else if (KEYS != 0) begin
                    nm = M_MAN; m_ret = M_IDLE; m_rel = 0;
                end else if (PLAY_BTN) begin
                    nm = M_AUTO; e.ss = 1'b1;
                    m_phase = 0; m_period = period_of(TEMPO);
                end
            end
            M_AUTO: begin
                if (STOP_BTN) nm = M_IDLE;
                else if (OVR && KEYS != 0) begin
                    nm = M_MAN; m_ret = M_AUTO; m_rel = 0;
                end else if (PLAY_BTN) nm = M_PAUSE;
            end
            M_PAUSE: begin
                if (STOP_BTN) nm = M_IDLE;
                else if (KEYS != 0) begin
                    nm = M_MAN; m_ret = M_PAUSE; m_rel = 0;
                end else if (PLAY_BTN) nm = M_AUTO;
            end
            default: begin
                if (STOP_BTN) m_ret = M_IDLE;
                if (KEYS != 0) m_rel = 0;
                else begin
                    m_rel++;
                    if (m_rel == REL) begin
                        m_rel = 0;
                        nm = m_ret;
                    end
                end
            end
        endcase
        if (nm == M_IDLE) m_phase = 0;
        m_mode = nm;
        case (nm)
            M_AUTO:  e.note = AUTO_NOTE;
            M_MAN:   e.note = 4'(lowest_key(KEYS));
            default: e.note = 4'd8;
        endcase
        e.src = 2'(nm);
        return e;
    endfunction

    // Inputs are applied just after a falling edge; the model result is
    // queued and compared at the following falling edge.
    task automatic cyc();
        exp_t e;
        if (!RESET_N) begin
            m_reset();
            e.qb = 1'b0; e.ss = 1'b0; e.note = 4'd8; e.src = 2'd0;
        end else begin
            e = m_step();
        end
        q.push_back(e);
        @(negedge CLK);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            AUTO_NOTE = 4'($urandom_range(0, 8));
            cyc();
        end
    endtask

    task automatic pulse_play();
        PLAY_BTN = 1'b1; cyc(); PLAY_BTN = 1'b0;
    endtask

    task automatic do_reset(int n);
        RESET_N = 1'b0;
        #1;
        chk("rst_note", 32'(NOTE), 32'd8);
        chk("rst_src", 32'(SRC), 32'd0);
        chk("rst_qb", 32'(QUARTER_BEAT), 32'd0);
        chk("rst_ss", 32'(SONG_START), 32'd0);
        repeat (n) cyc();
        RESET_N = 1'b1;
    endtask

    // Monitor: compare every presented output set with the queued model value.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("quarter_beat", 32'(QUARTER_BEAT), 32'(mon_e.qb));
            chk("song_start", 32'(SONG_START), 32'(mon_e.ss));
            chk("note", 32'(NOTE), 32'(mon_e.note));
            chk("src", 32'(SRC), 32'(mon_e.src));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int hold;
        RESET_N   = 1'b0;
        KEYS      = 8'd0;
        PLAY_BTN  = 1'b0;
        STOP_BTN  = 1'b0;
        TEMPO     = 2'd0;
        AUTO_NOTE = 4'd8;
        m_reset();
        @(negedge CLK);
        #1;
        do_reset(2);

        run(3);
        pulse_play();
        run(20);

        run(3);
        TEMPO = 2'd1;
        run(20);
        TEMPO = 2'd2;
        run(40);
        TEMPO = 2'd0;
        run(20);

        run(5);
        pulse_play();
        run(10);
        pulse_play();
        run(10);

        KEYS = 8'b0010_0100;
        run(3);
        KEYS = 8'd0;
        run(8);

        pulse_play();
        KEYS = 8'b1000_0000;
        run(2);
        KEYS = 8'd0;
        STOP_BTN = 1'b1;
        PLAY_BTN = 1'b1;
        cyc();
        STOP_BTN = 1'b0;
        PLAY_BTN = 1'b0;
        run(6);

        pulse_play();
        run(6);
        do_reset(1);
        run(20);

        KEYS = 8'b0001_0000;
        run(2);
        KEYS = 8'd0;
        run(6);

        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(2);
            end else begin
                if (hold == 0) begin
                    if ($urandom_range(0, 14) == 0) begin
                        KEYS = 8'($urandom_range(1, 255));
                        hold = $urandom_range(1, 6);
                    end else begin
                        KEYS = 8'd0;
                    end
                end else begin
                    hold--;
                end
                PLAY_BTN = ($urandom_range(0, 11) == 0);
                STOP_BTN = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 29) == 0) TEMPO = 2'($urandom_range(0, 3));
                AUTO_NOTE = 4'($urandom_range(0, 8));
                cyc();
                PLAY_BTN = 1'b0;
                STOP_BTN = 1'b0;
            end
        end

        @(negedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_source_arbiter.md
NOTE_SOURCE_ARBITER -- requirements
Module: note_source_arbiter

Interface
REQ-001 SHALL have parameter BASE_TICKS, default 12_500_000, meaning CLK cycles per quarter beat at TEMPO=0 (125 ms at 100 MHz).
REQ-002 SHALL have parameter RELEASE_CYC, default 1_000_000, meaning consecutive all-keys-released cycles before MANUAL exits.
REQ-003 SHALL have port CLK  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port KEYS  in  8  manual keys, level, synchronous; KEYS[i] requests note code i (0=C5 ... 7=C4).
REQ-006 SHALL have port PLAY_BTN  in  1  single-cycle synchronous pulse, play/pause toggle.
REQ-007 SHALL have port STOP_BTN  in  1  single-cycle synchronous pulse, stop.
REQ-008 SHALL have port TEMPO  in  2  quarter-beat period select.
REQ-009 SHALL have port AUTO_NOTE  in  4  note code from song sequencer (8 = none).
REQ-010 SHALL have port QUARTER_BEAT  out  1  one-cycle tick advancing the song sequencer.
REQ-011 SHALL have port SONG_START  out  1  one-cycle pulse restarting the song sequencer at step 0.
REQ-012 SHALL have port NOTE  out  4  note code to tone generator and LED decoder (8 = silent).
REQ-013 SHALL have port SRC  out  2  active source: 00 idle, 01 auto, 10 manual, 11 paused.

Function
REQ-014 SHALL implement states IDLE, AUTO, PAUSE, MANUAL; all outputs registered, one-cycle latency from inputs.
REQ-015 Event priority SHALL be STOP_BTN > KEYS nonzero > PLAY_BTN when simultaneous.
REQ-016 IDLE: NOTE=8, beat counter held at 0; PLAY_BTN -> AUTO with SONG_START high exactly one cycle on entry.
REQ-017 AUTO: NOTE=AUTO_NOTE; beat counter runs; PLAY_BTN -> PAUSE; STOP_BTN -> IDLE; KEYS nonzero -> MANUAL with return state AUTO.
REQ-018 PAUSE: NOTE=8; beat counter frozen at current value; PLAY_BTN -> AUTO without SONG_START (resume mid-beat); STOP_BTN -> IDLE; KEYS nonzero -> MANUAL with return state PAUSE.
REQ-019 IDLE with KEYS nonzero SHALL enter MANUAL with return state IDLE.
REQ-020 MANUAL: NOTE = index of lowest set KEYS bit, 8 if none; beat counter frozen; PLAY_BTN ignored; STOP_BTN sets return state IDLE.
REQ-021 MANUAL release counter SHALL count cycles with KEYS==0, clear on any key, and on reaching RELEASE_CYC transition to the return state.
REQ-022 Beat counter SHALL count 0..P-1, pulse QUARTER_BEAT on the cycle it equals P-1, then wrap to 0.
REQ-023 P SHALL be BASE_TICKS for TEMPO 0 or 3, BASE_TICKS/2 for 1, BASE_TICKS*2 for 2; TEMPO SHALL be latched only on a QUARTER_BEAT cycle or on IDLE->AUTO.
REQ-024 Beat counter width SHALL hold BASE_TICKS*2-1 without overflow.
REQ-025 Entering IDLE from any state SHALL clear the beat counter to 0.

Reset
REQ-026 RESET_N low SHALL immediately force state IDLE, NOTE=8, SRC=00, QUARTER_BEAT=0, SONG_START=0, beat and release counters 0, return state IDLE, latched TEMPO 0.
REQ-027 Reset asserted mid-note or mid-beat SHALL discard all progress; after release the block SHALL wait in IDLE for PLAY_BTN or KEYS.

Configuration
REQ-028 Macro KEY_OVERRIDE_EN defined: KEYS nonzero in AUTO enters MANUAL per REQ-017.
REQ-029 KEY_OVERRIDE_EN undefined: KEYS ignored in AUTO (song uninterrupted); KEYS still enter MANUAL from IDLE and PAUSE.

Verification (BASE_TICKS=8, RELEASE_CYC=4)
REQ-030 Reset release, PLAY_BTN pulse -> SONG_START one cycle, SRC=01, QUARTER_BEAT every 8 cycles, NOTE tracks AUTO_NOTE one cycle late.
REQ-031 AUTO, TEMPO 0->1 mid-beat -> current period stays 8, following ticks every 4 cycles; TEMPO=2 -> every 16.
REQ-032 AUTO at counter 5, PLAY_BTN -> SRC=11, NOTE=8, no ticks; PLAY_BTN again -> next tick 2 cycles later, no SONG_START.
REQ-033 KEY_OVERRIDE_EN, AUTO, KEYS=8'b0010_0100 -> NOTE=2, SRC=10; KEYS=0 for 4 cycles -> SRC=01, ticks resume; undefined macro -> NOTE stays AUTO_NOTE.
REQ-034 MANUAL, STOP_BTN and PLAY_BTN same cycle, then KEYS=0 for 4 cycles -> IDLE, NOTE=8, no SONG_START.
REQ-035 RESET_N low during AUTO at counter 6 -> outputs reset values same cycle, no QUARTER_BEAT after release until PLAY_BTN.
